// File: rtl/dtree_feature_sequencer_pkg.sv
// dtree_seq_pkg: shared state encoding and default sizing for the decision-tree feature sequencer
package dtree_seq_pkg;
    localparam int DEF_N_FEAT  = 5;
    localparam int DEF_FEAT_W  = 8;
    localparam int DEF_CLASS_W = 5;
    localparam int DEF_SETTLE  = 3;
    localparam int IDX_W       = $clog2(DEF_N_FEAT);
    localparam int CNT_W       = 8;
    typedef enum logic [1:0] {ST_LOAD, ST_DROP, ST_SETTLE, ST_OUT} state_t;
endpackage

// File: rtl/dtree_feature_sequencer_if.sv
// dtree_seq_if: feature stream in, core feature/class bus, class result out, status
// slave = sequencer view, master = environment (stream source, core, result sink)
interface dtree_seq_if #(
    parameter int N_FEAT  = 5,
    parameter int FEAT_W  = 8,
    parameter int CLASS_W = 5
);
    logic                     s_valid;
    logic                     s_ready;
    logic [FEAT_W-1:0]        s_data;
    logic                     s_last;
    logic [N_FEAT*FEAT_W-1:0] core_feat;
    logic [CLASS_W-1:0]       core_class;
    logic                     m_valid;
    logic                     m_ready;
    logic [CLASS_W-1:0]       m_class;
    logic                     err_len;
    logic                     busy;
    modport slave (
        input  s_valid, s_data, s_last, core_class, m_ready,
        output s_ready, core_feat, m_valid, m_class, err_len, busy
    );
    modport master (
        output s_valid, s_data, s_last, core_class, m_ready,
        input  s_ready, core_feat, m_valid, m_class, err_len, busy
    );
endinterface

// File: rtl/dtree_feature_sequencer_feat_regs.sv
// dtree_feat_regs: N_FEAT x FEAT_W feature register file driving the flattened core bus
// ports: clk, rst_n (async clear), we_i/idx_i/wdata_i write port, core_feat_o flattened features
module dtree_feat_regs #(
    parameter int N_FEAT = 5,
    parameter int FEAT_W = 8,
    parameter int IW     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [IW-1:0]            idx_i,
    input  logic [FEAT_W-1:0]        wdata_i,
    output logic [N_FEAT*FEAT_W-1:0] core_feat_o
);
    logic [N_FEAT*FEAT_W-1:0] feat_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) feat_q <= '0;
        else if (we_i)
            for (int k = 0; k < N_FEAT; k++)
                if (idx_i == IW'(k)) feat_q[k*FEAT_W +: FEAT_W] <= wdata_i;
    assign core_feat_o = feat_q;
endmodule

// File: rtl/dtree_feature_sequencer.sv
// dtree_feature_sequencer: loads a serial feature frame, waits for the slow core to settle, returns its class
// ports: clk, rst_n (async, active-low), bus (dtree_seq_if.slave: stream in, core bus, result out, err_len, busy)
module dtree_feature_sequencer
    import dtree_seq_pkg::*;
#(
    parameter int N_FEAT  = DEF_N_FEAT,
    parameter int FEAT_W  = DEF_FEAT_W,
    parameter int CLASS_W = DEF_CLASS_W,
    parameter int SETTLE  = DEF_SETTLE
) (
    input  logic        clk,
    input  logic        rst_n,
    dtree_seq_if.slave  bus
);
    localparam int IW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_FEAT - 1);
    state_t             state_q;
    logic [IW-1:0]      idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               m_valid_q;
    logic [CLASS_W-1:0] m_class_q;
    logic               err_len_q;
    logic               hs, at_last, we;
    assign bus.s_ready = (state_q == ST_LOAD) || (state_q == ST_DROP);
    assign bus.busy    = (state_q == ST_SETTLE) || (state_q == ST_OUT);
    assign hs          = bus.s_valid && bus.s_ready;
    assign at_last     = idx_q == LAST_IDX;
    // a beat is stored only when s_last agrees with the position: short and long frames write nothing
    assign we          = hs && state_q == ST_LOAD && (bus.s_last == at_last);
    dtree_feat_regs #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .IW(IW)) u_regs (
        .clk(clk), .rst_n(rst_n), .we_i(we), .idx_i(idx_q), .wdata_i(bus.s_data), .core_feat_o(bus.core_feat)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            idx_q     <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_class_q <= '0;
            err_len_q <= 1'b0;
        end else begin
            err_len_q <= 1'b0;
            case (state_q)
                ST_LOAD:
                    if (hs) begin
                        if (at_last) begin
                            idx_q <= '0;
                            if (bus.s_last) begin
                                cnt_q   <= CNT_W'(SETTLE - 1);
                                state_q <= ST_SETTLE;
                            end else begin
                                err_len_q <= 1'b1;
                                state_q   <= ST_DROP;
                            end
                        end else if (bus.s_last) begin
                            err_len_q <= 1'b1;
                            idx_q     <= '0;
                        end else idx_q <= idx_q + 1'b1;
                    end
                ST_DROP:
                    if (hs && bus.s_last) state_q <= ST_LOAD;
                ST_SETTLE:
                    if (cnt_q == '0) begin
                        m_class_q <= bus.core_class;
                        m_valid_q <= 1'b1;
                        state_q   <= ST_OUT;
                    end else cnt_q <= cnt_q - 1'b1;
                ST_OUT:
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ST_LOAD;
                    end
                default: state_q <= ST_LOAD;
            endcase
        end
    assign bus.m_valid = m_valid_q;
    assign bus.m_class = m_class_q;
    assign bus.err_len = err_len_q;
endmodule

// File: tb/tb_dtree_feature_sequencer.sv
// tb_dtree_feature_sequencer: directed scoreboard bench with a core model class = feature[4][7:3]
module tb_dtree_feature_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0, errors = 0, cyc = 0, res_cnt = 0, err_cnt = 0, res_cyc = 0, hs_cyc = 0;
    logic [4:0] exp_q[$];

    dtree_seq_if #(.N_FEAT(5), .FEAT_W(8), .CLASS_W(5)) bus();
    dtree_feature_sequencer #(.N_FEAT(5), .FEAT_W(8), .CLASS_W(5), .SETTLE(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    assign bus.core_class = bus.core_feat[39:35];
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // result handshake occurs at the next posedge; scoreboard pops here
    always @(negedge clk) begin
        if (rst_n && bus.err_len) err_cnt++;
        if (rst_n && bus.m_valid && bus.m_ready) begin
            res_cnt++;
            res_cyc = cyc + 1;
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("result_class", bus.m_class, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        @(negedge clk);
        while (!bus.s_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("beat_timeout", n, 0);
        tick();
        hs_cyc = cyc;
        bus.s_valid = 1'b0;
    endtask

    task automatic frame5(input logic [7:0] a, b, c, d, e);
        send_beat(a, 1'b0);
        send_beat(b, 1'b0);
        send_beat(c, 1'b0);
        send_beat(d, 1'b0);
        send_beat(e, 1'b1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.m_valid && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("valid_timeout", n, 0);
    endtask

    initial begin
        int n, e0, r0, b_first;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) tick();
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_core_feat", bus.core_feat, 0);
        chk("rst_m_class", bus.m_class, 0);
        chk("rst_err_len", bus.err_len, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick();

        // nominal frame: valid appears SETTLE edges after the last-beat handshake edge
        exp_q.push_back(5'h11);
        frame5(8'h0A, 8'h14, 8'h1E, 8'h28, 8'h88);
        chk("nom_busy", bus.busy, 1);
        chk("nom_s_ready_settle", bus.s_ready, 0);
        wait_valid(n);
        chk("nom_latency", n, 3);
        chk("nom_m_class", bus.m_class, 5'h11);
        chk("nom_core_feat", bus.core_feat, 40'h88281E140A);
        tick();
        chk("nom_valid_one_cycle", bus.m_valid, 0);
        chk("nom_s_ready_after", bus.s_ready, 1);

        // backpressure
        bus.m_ready = 1'b0;
        exp_q.push_back(5'h11);
        frame5(8'h0A, 8'h14, 8'h1E, 8'h28, 8'h88);
        wait_valid(n);
        for (int i = 0; i < 10; i++) begin
            chk("bp_m_valid", bus.m_valid, 1);
            chk("bp_m_class", bus.m_class, 5'h11);
            chk("bp_s_ready", bus.s_ready, 0);
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        chk("bp_release_valid", bus.m_valid, 0);
        chk("bp_release_s_ready", bus.s_ready, 1);

        // short frame
        e0 = err_cnt;
        r0 = res_cnt;
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b1);
        chk("short_err_pulse", bus.err_len, 1);
        chk("short_s_ready", bus.s_ready, 1);
        tick();
        chk("short_err_clear", bus.err_len, 0);
        repeat (8) tick();
        chk("short_err_count", err_cnt - e0, 1);
        chk("short_no_result", res_cnt - r0, 0);
        exp_q.push_back(5'h1F);
        frame5(8'h11, 8'h22, 8'h33, 8'h44, 8'hF8);
        wait_valid(n);
        chk("short_next_class", bus.m_class, 5'h1F);
        tick();

        // long frame
        e0 = err_cnt;
        r0 = res_cnt;
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h04, 1'b0);
        send_beat(8'h55, 1'b0);
        chk("long_err_pulse", bus.err_len, 1);
        chk("long_drop_s_ready", bus.s_ready, 1);
        send_beat(8'h66, 1'b0);
        chk("long_err_clear", bus.err_len, 0);
        send_beat(8'h77, 1'b1);
        chk("long_feat4_kept", bus.core_feat[39:32], 8'hF8);
        chk("long_feat0", bus.core_feat[7:0], 8'h01);
        repeat (8) tick();
        chk("long_err_count", err_cnt - e0, 1);
        chk("long_no_result", res_cnt - r0, 0);
        chk("long_no_valid", bus.m_valid, 0);
        exp_q.push_back(5'h0A);
        frame5(8'h10, 8'h20, 8'h30, 8'h40, 8'h50);
        wait_valid(n);
        chk("long_next_latency", n, 3);
        chk("long_next_class", bus.m_class, 5'h0A);
        tick();

        // reset during SETTLE
        r0 = res_cnt;
        frame5(8'h09, 8'h08, 8'h07, 8'h06, 8'hE0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_m_valid", bus.m_valid, 0);
        chk("rstmid_core_feat", bus.core_feat, 0);
        chk("rstmid_s_ready", bus.s_ready, 1);
        chk("rstmid_busy", bus.busy, 0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("rstmid_no_result", res_cnt - r0, 0);
        chk("rstmid_no_valid", bus.m_valid, 0);
        chk("rstmid_s_ready_after", bus.s_ready, 1);

        // back-to-back frames with s_valid held high
        r0 = res_cnt;
        exp_q.push_back(5'h07);
        exp_q.push_back(5'h18);
        frame5(8'h01, 8'h02, 8'h03, 8'h04, 8'h38);
        send_beat(8'h05, 1'b0);
        b_first = hs_cyc;
        chk("b2b_order", b_first, res_cyc + 1);
        chk("b2b_a_done", res_cnt - r0, 1);
        send_beat(8'h06, 1'b0);
        send_beat(8'h07, 1'b0);
        send_beat(8'h08, 1'b0);
        send_beat(8'hC0, 1'b1);
        wait_valid(n);
        chk("b2b_b_class", bus.m_class, 5'h18);
        tick();
        chk("b2b_results", res_cnt - r0, 2);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dtree_feature_sequencer.md
Name: dtree_feature_sequencer

Overview:
- Sequencer that sits in front of a combinational printed decision-tree classifier core.
- Accepts a feature vector as a serial byte stream (one feature per beat) and holds all features stable on the core inputs.
- Waits a programmable settle time, since printed logic is slow, then samples the core's class output.
- Presents the class on a valid/ready output channel. Malformed frames are detected and discarded.

Parameters:
- N_FEAT, 5, number of features per frame (beats per frame).
- FEAT_W, 8, width of one feature.
- CLASS_W, 5, width of the class code returned by the core.
- SETTLE, 3, core settle time in clk cycles; legal range 1..255.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  feature beat valid.
- s_ready  output  1  feature beat accepted when s_valid && s_ready.
- s_data  input  FEAT_W  feature value; beat k carries feature index k.
- s_last  input  1  marks the final beat of a frame.
- core_feat  output  N_FEAT*FEAT_W  registered features to the core; feature k occupies bits [k*FEAT_W +: FEAT_W].
- core_class  input  CLASS_W  combinational class result from the core.
- m_valid  output  1  class result valid.
- m_ready  input  1  downstream accepts the result.
- m_class  output  CLASS_W  captured class.
- err_len  output  1  one-cycle pulse on a frame-length error.
- busy  output  1  high in SETTLE or OUT.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state=LOAD, idx=0, core_feat=0, m_class=0, m_valid=0, err_len=0, settle counter=0. s_ready=1 after reset.
- State LOAD: s_ready=1.
  - On handshake with idx<N_FEAT-1 and s_last=0: write feature[idx]=s_data, idx++.
  - On handshake with idx=N_FEAT-1 and s_last=1: write feature[idx], idx=0, load cnt=SETTLE-1, go to SETTLE.
  - Short frame (s_last=1 with idx<N_FEAT-1): write nothing further, pulse err_len, idx=0, stay in LOAD.
  - Long frame (handshake at idx=N_FEAT-1 with s_last=0): write nothing, pulse err_len, idx=0, go to DROP.
- State DROP: s_ready=1. Discard beats; on a handshake with s_last=1 go to LOAD. No further err_len pulses.
- State SETTLE: s_ready=0, core_feat frozen.
  - cnt decrements each cycle.
  - In the cycle cnt==0: m_class<=core_class, m_valid<=1, go to OUT.
  - Latency: last beat accepted in cycle t, m_valid first high in cycle t+SETTLE+1.
- State OUT: s_ready=0. m_valid and m_class are held stable until m_ready. On m_valid && m_ready: m_valid<=0, go to LOAD; s_ready is 1 in the next cycle.
- core_feat updates only on LOAD writes. Previously written features persist across frames until overwritten.
- busy = (state==SETTLE || state==OUT).
- A partially loaded frame interrupted by reset is lost; no error pulse.
- Reset asserted in SETTLE/OUT: m_valid clears immediately (asynchronously), and no result is emitted after reset release.
- All outputs are registered except s_ready and busy, which decode the state.
- idx width is $clog2(N_FEAT); cnt width is 8.

Decomposition:
- Shared package dtree_seq_pkg:
  - state enum {LOAD, DROP, SETTLE, OUT};
  - default parameter constants;
  - localparam IDX_W=$clog2(N_FEAT).
- One sub-module: dtree_feat_regs, the N_FEAT x FEAT_W feature register file.
  - Inputs: write enable and index.
  - Output: flattened core_feat bus.
  - Asynchronous clear on rst_n.
- FSM and settle counter stay in the top.

Test Plan:
All scenarios use SETTLE=3 and a bench core model with core_class = core_feat[4][7:3].
- Nominal frame: beats 0x0A,0x14,0x1E,0x28,0x88 (last on the 5th), m_ready=1 -> m_class=0x11, m_valid exactly 4 cycles after the last handshake, high for 1 cycle; core_feat[39:32]=0x88.
- Backpressure: same frame with m_ready=0 for 10 cycles -> m_valid and m_class=0x11 held stable; s_ready=0 throughout; s_ready=1 the cycle after m_ready rises.
- Short frame: 3 beats, s_last on the 3rd -> err_len pulses once, no m_valid; a following valid frame ending 0xF8 -> m_class=0x1F.
- Long frame: 7 beats, s_last on the 7th -> err_len pulses once at the 5th beat, beats 5-7 discarded, no m_valid; the next frame is processed normally.
- Reset mid-SETTLE: drop rst_n one cycle after the last beat -> m_valid=0, core_feat=0, s_ready=1 after release; no stale result appears.
- Back-to-back frames, s_valid held high: frame B is accepted only after frame A's result handshake; each frame's m_class matches its 5th feature >> 3.
